fir_cascade_lid: RTL and testbench

//  Latency-insensitive (LID) shell around an N-tap cascaded FIR filter on signed 16-bit samples.

---
 rtl/fir_cascade_lid.sv | 125 ++++++++++++
 tb/tb_fir_cascade_lid.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_cascade_lid.sv
// fir_cascade_lid: latency-insensitive shell (input queue + registered output stage) around an
// N-tap cascaded FIR. Each fire shifts one sample into the delay line and registers a saturated output.

module fir_cascade_mac #(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int ACC_W   = 35,
  parameter logic signed [COEFF_W-1:0] COEFF = '0
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [ACC_W-1:0]  acc_out
);
  logic signed [ACC_W-1:0] xe, ce;

  assign xe      = ACC_W'(x);
  assign ce      = ACC_W'(COEFF);
  assign acc_out = acc_in + xe * ce;
endmodule

module fir_cascade_lid #(
  parameter int DATA_W     = 16,
  parameter int COEFF_W    = 16,
  parameter int N_TAPS     = 8,
  parameter logic [N_TAPS*COEFF_W-1:0] COEFFS =
    {COEFF_W'(1), {((N_TAPS-1)*COEFF_W){1'b0}}},
  parameter int SHIFT      = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_top_valid,
  input  logic [DATA_W-1:0] i_top_data_data,
  input  logic              i_top_data_valid,
  output logic              o_top_stop,
  output logic              o_top_valid,
  output logic [DATA_W-1:0] o_top_data_data,
  output logic              o_top_data_valid,
  input  logic              i_top_stop
);
  localparam int ACC_W = DATA_W + COEFF_W + $clog2(N_TAPS);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'({(DATA_W-1){1'b1}});
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  logic [FIFO_DEPTH-1:0][DATA_W-1:0] q_data;
  logic [FIFO_DEPTH-1:0]             q_dv;
  logic [PW-1:0]                     wr_ptr, rd_ptr;
  logic [CW-1:0]                     count, count_nx;
  logic                              push, fire, head_dv;

  logic [N_TAPS-1:0][DATA_W-1:0] x_new;
  logic [N_TAPS-2:0][DATA_W-1:0] x_dl;
  logic [N_TAPS:0][ACC_W-1:0]    casc;
  logic signed [ACC_W-1:0]       acc, acc_sh;
  logic [DATA_W-1:0]             y;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push     = i_top_valid & ~o_top_stop;
  assign fire     = (count != '0) & ~i_top_stop;
  assign count_nx = count + CW'(push) - CW'(fire);
  assign head_dv  = q_dv[rd_ptr];

  // Cleared-data tokens still advance the line as zero samples.
  assign x_new = {x_dl, head_dv ? q_data[rd_ptr] : DATA_W'(0)};

  assign casc[0] = '0;
  for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
    fir_cascade_mac #(
      .DATA_W (DATA_W),
      .COEFF_W(COEFF_W),
      .ACC_W  (ACC_W),
      .COEFF  (COEFFS[(N_TAPS-1-k)*COEFF_W +: COEFF_W])
    ) u_mac (
      .x      (x_new[k]),
      .acc_in (casc[k]),
      .acc_out(casc[k+1])
    );
  end

  assign acc    = casc[N_TAPS];
  assign acc_sh = acc >>> SHIFT;

  always_comb begin
    y = acc_sh[DATA_W-1:0];
    if (acc_sh > Y_MAX)      y = Y_MAX[DATA_W-1:0];
    else if (acc_sh < Y_MIN) y = Y_MIN[DATA_W-1:0];
  end

  // Queue storage needs no reset: occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (push) begin
      q_data[wr_ptr] <= i_top_data_data;
      q_dv[wr_ptr]   <= i_top_data_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      o_top_stop       <= 1'b0;
      x_dl             <= '0;
      o_top_valid      <= 1'b0;
      o_top_data_valid <= 1'b0;
      o_top_data_data  <= '0;
    end else begin
      count       <= count_nx;
      o_top_stop  <= (count_nx == CW'(FIFO_DEPTH));
      o_top_valid <= fire;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (fire) begin
        rd_ptr           <= ptr_inc(rd_ptr);
        x_dl             <= x_new[N_TAPS-2:0];
        o_top_data_data  <= y;
        o_top_data_valid <= head_dv;
      end
    end
  end
endmodule

// File: tb/tb_fir_cascade_lid.sv
// Bench for fir_cascade_lid: three coefficient sets share one stimulus stream and are checked
// against a sum-of-products reference over the accepted-sample history.

module tb_fir_cascade_lid;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic i_valid = 1'b0, i_dv = 1'b0, i_stop = 1'b0;
  logic signed [15:0] i_data = '0;
  logic [2:0] ov, odv, ostop;
  logic signed [15:0] od [3];

  int total = 0, bad = 0;
  int n_acc = 0, n_out = 0, n_dv0 = 0;

  typedef struct packed {
    logic            dv;
    logic [2:0][15:0] y;
  } exp_t;

  exp_t expq[$];
  int   hist[$];
  int   log0[$], log1[$], log2[$];
  int   cf [3][8] = '{'{1,0,0,0,0,0,0,0}, '{1,1,0,0,0,0,0,0}, '{2,0,0,0,0,0,0,0}};
  int   exp_a [3][6] = '{'{0,1,2,3,20000,-20000}, '{0,1,3,5,20003,0}, '{0,2,4,6,32767,-32768}};

  always #5 clock = ~clock;

  fir_cascade_lid u_id (
    .clock(clock), .reset(reset), .i_top_valid(i_valid), .i_top_data_data(i_data),
    .i_top_data_valid(i_dv), .o_top_stop(ostop[0]), .o_top_valid(ov[0]),
    .o_top_data_data(od[0]), .o_top_data_valid(odv[0]), .i_top_stop(i_stop));

  fir_cascade_lid #(.COEFFS({16'sd1, 16'sd1, {6{16'sd0}}})) u_pair (
    .clock(clock), .reset(reset), .i_top_valid(i_valid), .i_top_data_data(i_data),
    .i_top_data_valid(i_dv), .o_top_stop(ostop[1]), .o_top_valid(ov[1]),
    .o_top_data_data(od[1]), .o_top_data_valid(odv[1]), .i_top_stop(i_stop));

  fir_cascade_lid #(.COEFFS({16'sd2, {7{16'sd0}}})) u_dbl (
    .clock(clock), .reset(reset), .i_top_valid(i_valid), .i_top_data_data(i_data),
    .i_top_data_valid(i_dv), .o_top_stop(ostop[2]), .o_top_valid(ov[2]),
    .o_top_data_data(od[2]), .o_top_data_valid(odv[2]), .i_top_stop(i_stop));

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: every accepted token produces one expected output, in order.
  always @(posedge clock) begin
    exp_t   e;
    longint a;
    int     x;
    if (reset) begin
      hist.delete();
      expq.delete();
    end else if (i_valid && !ostop[0]) begin
      x = i_dv ? int'(i_data) : 0;
      hist.push_front(x);
      if (hist.size() > 8) void'(hist.pop_back());
      e.dv = i_dv;
      for (int d = 0; d < 3; d++) begin
        a = 0;
        for (int k = 0; k < hist.size(); k++) a += longint'(cf[d][k]) * hist[k];
        if (a > 32767) a = 32767;
        else if (a < -32768) a = -32768;
        e.y[d] = 16'(a);
      end
      expq.push_back(e);
      n_acc++;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset && ov[0]) begin
      n_out++;
      chk("valid_agree", ov, 3'b111);
      if (expq.size() == 0) chk("spurious_out", ov[0], 0);
      else begin
        e = expq.pop_front();
        chk("out_dv", odv[0], e.dv);
        for (int d = 0; d < 3; d++) chk($sformatf("y%0d", d), od[d], longint'($signed(e.y[d])));
        if (odv[0]) begin
          log0.push_back(int'(od[0]));
          log1.push_back(int'(od[1]));
          log2.push_back(int'(od[2]));
        end else n_dv0++;
      end
    end
  end

  // Offer one token until accepted, honouring o_top_stop; random voids and downstream stop.
  task automatic put(input int s, input logic dv, input int void_pct, input int stop_pct);
    logic st;
    for (int n = 0; n < 500; n++) begin
      i_stop = ($urandom_range(99) < stop_pct);
      if ($urandom_range(99) < void_pct) begin
        i_valid = 1'b0;
        i_data  = 16'($urandom);
        i_dv    = 1'($urandom);
        @(posedge clock); #1;
      end else begin
        i_valid = 1'b1;
        i_data  = 16'(s);
        i_dv    = dv;
        st      = ostop[0];
        @(posedge clock); #1;
        if (!st) begin
          i_valid = 1'b0;
          return;
        end
      end
    end
    i_valid = 1'b0;
    chk("put_timeout", ostop[0], 0);
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_stop  = 1'b0;
    for (int n = 0; n < 100 && expq.size() != 0; n++) begin
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    chk("drain", expq.size(), 0);
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    log2.delete();
  endtask

  initial begin
    int base;
    // Reset state
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_valid", ov[0], 0);
    chk("rst_dvalid", odv[0], 0);
    chk("rst_stop", ostop[0], 0);
    chk("rst_data", od[0], 0);

    // Short sequence plus saturation pair, with voids
    for (int i = 0; i < 4; i++) put(i, 1'b1, 30, 0);
    put(20000, 1'b1, 30, 0);
    put(-20000, 1'b1, 30, 0);
    drain();
    chk("seq_len0", log0.size(), 6);
    chk("seq_len1", log1.size(), 6);
    chk("seq_len2", log2.size(), 6);
    for (int i = 0; i < 6 && i < log0.size() && i < log1.size() && i < log2.size(); i++) begin
      chk($sformatf("id_%0d", i), log0[i], exp_a[0][i]);
      chk($sformatf("pair_%0d", i), log1[i], exp_a[1][i]);
      chk($sformatf("dbl_%0d", i), log2[i], exp_a[2][i]);
    end

    // Downstream stop held: queue fills, third sample held upstream
    clear_logs();
    base = n_acc;
    put(0, 1'b1, 0, 100);
    put(1, 1'b1, 0, 100);
    chk("stop_full", ostop[0], 1);
    i_valid = 1'b1; i_data = 16'sd2; i_dv = 1'b1; i_stop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      chk("held_valid", ov[0], 0);
      chk("held_stop", ostop[0], 1);
    end
    chk("held_accepts", n_acc - base, 2);
    base = n_out;
    put(2, 1'b1, 0, 0);
    drain();
    chk("rel_outs", n_out - base, 3);
    chk("rel_len", log0.size(), 3);
    for (int i = 0; i < 3 && i < log0.size(); i++) chk($sformatf("rel_%0d", i), log0[i], i);

    // Identity stream 0..199 with voids, random stop and scattered cleared-data tokens
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    clear_logs();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(9) == 0) put(int'($urandom_range(65535)) - 32768, 1'b0, 30, 50);
      put(i, 1'b1, 30, 50);
    end
    drain();
    chk("stream_len", log0.size(), 200);
    begin
      int miss = 0;
      for (int i = 0; i < log0.size(); i++) if (log0[i] != i) miss++;
      chk("stream_match", miss, 0);
    end

    // Cleared-data tokens after the stream
    base = n_dv0;
    for (int i = 0; i < 3; i++) put(int'($urandom_range(1000)), 1'b0, 20, 30);
    drain();
    chk("dv0_tokens", n_dv0 - base, 3);

    // Reset mid-operation discards queued tokens
    put(11, 1'b1, 0, 100);
    put(12, 1'b1, 0, 100);
    base = n_out;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_stop", ostop[0], 0);
    chk("midrst_valid", ov[0], 0);
    i_stop = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("midrst_discard", n_out - base, 0);

    // Minimum latency: accepted at edge t, visible after edge t+1
    put(7, 1'b1, 0, 0);
    chk("lat_t", ov[0], 0);
    @(posedge clock); #1;
    chk("lat_t1", ov[0], 1);
    chk("lat_data", od[0], 7);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", total, 0);
    $fatal(1, "timeout");
  end
endmodule
